// File: rtl/ps2_keyb_ctrl.sv
// PS/2 keyboard host command sequencer: power-up reset, 0xED LED update with retry/timeout, scancode buffering.
// Define PS2_KEYB_CTRL_FIFO_EN for a 2**FIFO_AW-deep scancode FIFO; otherwise a single holding register.
module ps2_keyb_ctrl #(
  parameter int unsigned TIMEOUT   = 983040,
  parameter int unsigned TW        = 20,
  parameter int unsigned RETRY_MAX = 3,
  parameter int unsigned FIFO_AW   = 4
) (
  input  logic       wb_clk_i,
  input  logic       wb_rst_i,
  input  logic [2:0] led_set_i,
  input  logic       led_wr_i,
  output logic       busy_o,
  output logic       init_done_o,
  output logic       err_o,
  output logic       ovf_o,
  output logic [7:0] tx_dat_o,
  output logic       tx_req_o,
  input  logic       tx_ack_i,
  input  logic [7:0] rx_dat_i,
  input  logic       rx_stb_i,
  output logic [7:0] key_dat_o,
  output logic       key_vld_o,
  input  logic       key_rd_i
);

  localparam int unsigned RW = $clog2(RETRY_MAX + 2);

  typedef enum logic [3:0] {
    RST_TX, RST_ACK, RST_BAT, IDLE, CMD_TX, CMD_ACK, DAT_TX, DAT_ACK, ERR
  } state_t;

  state_t          state;
  state_t          ack_st, done_st, resend_st;
  logic [TW-1:0]   timer;
  logic [RW-1:0]   retry;
  logic            pending;
  logic [2:0]      mask_q;
  logic [7:0]      tx_byte;
  logic            timeout, retry_hit;
  logic            rsp_ok, rsp_retry, rsp_fatal, rx_take, push;
  logic            is_fa, is_fe, is_aa, is_fc;

  assign busy_o    = (state != IDLE);
  assign timeout   = (timer == TW'(TIMEOUT - 1));
  assign retry_hit = (retry == RW'(RETRY_MAX));
  assign is_fa     = rx_stb_i && (rx_dat_i == 8'hFA);
  assign is_fe     = rx_stb_i && (rx_dat_i == 8'hFE);
  assign is_aa     = rx_stb_i && (rx_dat_i == 8'hAA);
  assign is_fc     = rx_stb_i && (rx_dat_i == 8'hFC);

  // Per-state response decode; only bytes a state is waiting for are kept out of the buffer.
  always_comb begin
    rsp_ok    = 1'b0;
    rsp_retry = 1'b0;
    rsp_fatal = 1'b0;
    rx_take   = 1'b0;
    ack_st    = RST_ACK;
    done_st   = IDLE;
    resend_st = RST_TX;
    tx_byte   = 8'hFF;
    case (state)
      RST_TX:  ack_st = RST_ACK;
      CMD_TX:  begin ack_st = CMD_ACK; tx_byte = 8'hED; end
      DAT_TX:  begin ack_st = DAT_ACK; tx_byte = {5'b0, mask_q}; end
      RST_ACK: begin
        rsp_ok = is_fa; rsp_retry = is_fe || timeout; rx_take = is_fa || is_fe;
        done_st = RST_BAT; resend_st = RST_TX;
      end
      RST_BAT: begin
        rsp_ok = is_aa; rsp_fatal = is_fc; rsp_retry = timeout; rx_take = is_aa || is_fc;
        done_st = IDLE; resend_st = RST_TX;
      end
      CMD_ACK: begin
        rsp_ok = is_fa; rsp_retry = is_fe || timeout; rx_take = is_fa || is_fe;
        done_st = DAT_TX; resend_st = CMD_TX;
      end
      DAT_ACK: begin
        rsp_ok = is_fa; rsp_retry = is_fe || timeout; rx_take = is_fa || is_fe;
        done_st = IDLE; resend_st = DAT_TX;
      end
      default: ;
    endcase
  end

  assign push = rx_stb_i && !rx_take;

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state       <= RST_TX;
      tx_req_o    <= 1'b0;
      tx_dat_o    <= 8'h00;
      timer       <= '0;
      retry       <= '0;
      pending     <= 1'b0;
      mask_q      <= '0;
      init_done_o <= 1'b0;
      err_o       <= 1'b0;
    end else begin
      if (led_wr_i && state != IDLE) pending <= 1'b1;
      case (state)
        RST_TX, CMD_TX, DAT_TX: begin
          if (tx_req_o && tx_ack_i) begin
            tx_req_o <= 1'b0;
            state    <= ack_st;
            timer    <= '0;
          end else if (!tx_req_o) begin
            tx_req_o <= 1'b1;
            tx_dat_o <= tx_byte;
          end
        end
        RST_ACK, RST_BAT, CMD_ACK, DAT_ACK: begin
          timer <= timer + 1'b1;
          if (rsp_ok) begin
            state <= done_st;
            retry <= '0;
            timer <= '0;
            if (state == RST_BAT) init_done_o <= 1'b1;
          end else if (rsp_fatal) begin
            state <= ERR;
            err_o <= 1'b1;
            retry <= '0;
          end else if (rsp_retry) begin
            if (retry_hit) begin
              state <= ERR;
              err_o <= 1'b1;
              retry <= '0;
            end else begin
              retry <= retry + 1'b1;
              state <= resend_st;
            end
          end
        end
        IDLE: begin
          if (led_wr_i || pending) begin
            state   <= CMD_TX;
            mask_q  <= led_set_i;
            pending <= 1'b0;
            retry   <= '0;
          end
        end
        ERR:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef PS2_KEYB_CTRL_FIFO_EN
  localparam int unsigned DEPTH = 2 ** FIFO_AW;

  logic [7:0]       mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
  logic [FIFO_AW:0] count;
  logic             pop_ok, push_ok, full;

  assign full      = (count == (FIFO_AW + 1)'(DEPTH));
  assign pop_ok    = key_rd_i && (count != '0);
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
  assign push_ok   = push && (!full || pop_ok);
  assign key_vld_o = (count != '0);
  assign key_dat_o = key_vld_o ? mem[rd_ptr] : 8'h00;

  always_ff @(posedge wb_clk_i) begin
    if (push_ok) mem[wr_ptr] <= rx_dat_i;
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf_o  <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      if (push_ok && !pop_ok)      count <= count + 1'b1;
      else if (pop_ok && !push_ok) count <= count - 1'b1;
      if (push && !push_ok) ovf_o <= 1'b1;
    end
  end
`else
  logic [7:0] hold;
  logic       vld, pop_ok, push_ok;

  assign pop_ok    = key_rd_i && vld;
  assign push_ok   = push && (!vld || pop_ok);
  assign key_vld_o = vld;
  assign key_dat_o = vld ? hold : 8'h00;

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      hold  <= 8'h00;
      vld   <= 1'b0;
      ovf_o <= 1'b0;
    end else begin
      if (push_ok) begin
        hold <= rx_dat_i;
        vld  <= 1'b1;
      end else if (pop_ok) begin
        vld  <= 1'b0;
      end
      if (push && !push_ok) ovf_o <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_ps2_keyb_ctrl.sv
// Directed bench for ps2_keyb_ctrl: keyboard responder tasks, queue model of the scancode buffer.
module tb_ps2_keyb_ctrl;
`ifdef PS2_KEYB_CTRL_FIFO_EN
  localparam int DEPTH = 16;
`else
  localparam int DEPTH = 1;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] led_set = '0;
  logic       led_wr = 1'b0;
  logic       busy_o, init_done_o, err_o, ovf_o, tx_req_o, key_vld_o;
  logic [7:0] tx_dat_o, key_dat_o;
  logic       tx_ack = 1'b0;
  logic [7:0] rx_dat = '0;
  logic       rx_stb = 1'b0;
  logic       rx_push = 1'b0;
  logic       key_rd = 1'b0;

  int n_chk = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;
  logic [7:0] mq[$];
  bit m_ovf = 1'b0;

  always #5 clk = ~clk;

  ps2_keyb_ctrl #(.TIMEOUT(100), .TW(8), .RETRY_MAX(3), .FIFO_AW(4)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .led_set_i(led_set), .led_wr_i(led_wr),
    .busy_o(busy_o), .init_done_o(init_done_o), .err_o(err_o), .ovf_o(ovf_o),
    .tx_dat_o(tx_dat_o), .tx_req_o(tx_req_o), .tx_ack_i(tx_ack),
    .rx_dat_i(rx_dat), .rx_stb_i(rx_stb),
    .key_dat_o(key_dat_o), .key_vld_o(key_vld_o), .key_rd_i(key_rd)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Buffer model: a pop frees a slot before the same-cycle push is accepted.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete();
      m_ovf = 1'b0;
    end else begin
      if (key_rd && mq.size() > 0) void'(mq.pop_front());
      if (rx_stb && rx_push) begin
        if (mq.size() < DEPTH) mq.push_back(rx_dat);
        else m_ovf = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("key_vld", key_vld_o, mq.size() != 0);
      if (mq.size() != 0) check("key_dat", key_dat_o, mq[0]);
      check("ovf", ovf_o, m_ovf);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_rx(input logic [7:0] b, input bit to_buf);
    rx_dat = b; rx_push = to_buf; rx_stb = 1'b1;
    tick();
    rx_stb = 1'b0; rx_push = 1'b0;
  endtask

  task automatic pulse_led(input logic [2:0] m);
    led_set = m; led_wr = 1'b1;
    tick();
    led_wr = 1'b0;
  endtask

  task automatic pop();
    key_rd = 1'b1;
    tick();
    key_rd = 1'b0;
  endtask

  task automatic expect_tx(input logic [7:0] b, input bit with_rx, input logic [7:0] rxb);
    int n = 0;
    while (!tx_req_o && n < 300) begin tick(); n++; end
    check("tx_req_wait", tx_req_o, 1'b1);
    check("tx_dat", tx_dat_o, b);
    tx_ack = 1'b1;
    if (with_rx) begin rx_dat = rxb; rx_push = 1'b1; rx_stb = 1'b1; end
    tick();
    tx_ack = 1'b0; rx_stb = 1'b0; rx_push = 1'b0;
    check("tx_req_drop", tx_req_o, 1'b0);
  endtask

  initial begin
    int n;
    repeat (3) tick();
    chk_en = 1'b1;
    check("rst_busy", busy_o, 1'b1);
    check("rst_tx_req", tx_req_o, 1'b0);
    check("rst_tx_dat", tx_dat_o, 8'h00);
    check("rst_init", init_done_o, 1'b0);
    check("rst_err", err_o, 1'b0);
    check("rst_key_dat", key_dat_o, 8'h00);
    rst = 1'b0;

    // power-up: FF, FA, AA
    expect_tx(8'hFF, 1'b0, 8'h00);
    send_rx(8'hFA, 1'b0);
    check("bat_wait_busy", busy_o, 1'b1);
    check("bat_wait_init", init_done_o, 1'b0);
    send_rx(8'hAA, 1'b0);
    check("init_done", init_done_o, 1'b1);
    check("init_busy", busy_o, 1'b0);
    check("init_err", err_o, 1'b0);

    // LED update 101
    pulse_led(3'b101);
    expect_tx(8'hED, 1'b0, 8'h00);
    send_rx(8'hFA, 1'b0);
    expect_tx(8'h05, 1'b0, 8'h00);
    check("led_busy_before", busy_o, 1'b1);
    send_rx(8'hFA, 1'b0);
    check("led_busy_after", busy_o, 1'b0);

    // pending write while busy uses the mask present when IDLE is left
    pulse_led(3'b011);
    expect_tx(8'hED, 1'b0, 8'h00);
    pulse_led(3'b100);
    led_set = 3'b111;
    send_rx(8'hFA, 1'b0);
    expect_tx(8'h03, 1'b0, 8'h00);
    send_rx(8'hFA, 1'b0);
    expect_tx(8'hED, 1'b0, 8'h00);
    send_rx(8'hFA, 1'b0);
    expect_tx(8'h07, 1'b0, 8'h00);
    send_rx(8'hFA, 1'b0);
    tick(); tick();
    check("pend_done_busy", busy_o, 1'b0);
    check("pend_done_req", tx_req_o, 1'b0);

    // two resends then success
    pulse_led(3'b010);
    for (int i = 0; i < 2; i++) begin
      expect_tx(8'hED, 1'b0, 8'h00);
      send_rx(8'hFE, 1'b0);
    end
    expect_tx(8'hED, 1'b0, 8'h00);
    send_rx(8'hFA, 1'b0);
    expect_tx(8'h02, 1'b0, 8'h00);
    send_rx(8'hFA, 1'b0);
    check("retry_ok_err", err_o, 1'b0);
    check("retry_ok_busy", busy_o, 1'b0);

    // four FE answers exhaust the retries
    pulse_led(3'b001);
    for (int i = 0; i < 4; i++) begin
      expect_tx(8'hED, 1'b0, 8'h00);
      send_rx(8'hFE, 1'b0);
    end
    check("retry_err", err_o, 1'b1);
    check("retry_err_busy", busy_o, 1'b1);
    tick();
    check("err_idle_busy", busy_o, 1'b0);
    check("err_sticky", err_o, 1'b1);
    check("err_no_tx", tx_req_o, 1'b0);

    // data byte timeout: 100 cycles in DAT_ACK, request rises one cycle later
    pulse_led(3'b110);
    expect_tx(8'hED, 1'b0, 8'h00);
    send_rx(8'hFA, 1'b0);
    expect_tx(8'h06, 1'b0, 8'h00);
    n = 0;
    while (!tx_req_o && n < 300) begin tick(); n++; end
    check("timeout_cycles", n, 101);
    expect_tx(8'h06, 1'b0, 8'h00);
    send_rx(8'hFA, 1'b0);
    check("timeout_busy", busy_o, 1'b0);

    // scancodes during a command; FA coinciding with tx_ack is a scancode
    pulse_led(3'b101);
    expect_tx(8'hED, 1'b0, 8'h00);
    send_rx(8'h1C, 1'b1);
    check("sc0", key_dat_o, 8'h1C);
    pop();
    send_rx(8'hF0, 1'b1);
    check("sc1", key_dat_o, 8'hF0);
    pop();
    send_rx(8'hFA, 1'b0);
    send_rx(8'h1C, 1'b1);
    check("sc2", key_dat_o, 8'h1C);
    pop();
    expect_tx(8'h05, 1'b1, 8'hFA);
    check("ack_rx_pushed", key_dat_o, 8'hFA);
    check("ack_rx_busy", busy_o, 1'b1);
    pop();
    send_rx(8'hFA, 1'b0);
    check("sc_cmd_done", busy_o, 1'b0);
    pop();
    check("pop_empty_vld", key_vld_o, 1'b0);

    // hot-plug BAT in IDLE
    send_rx(8'hAA, 1'b1);
    check("hotplug_dat", key_dat_o, 8'hAA);
    check("hotplug_init", init_done_o, 1'b1);
    pop();

    // fill, push+pop when full, then overflow
    for (int i = 0; i < DEPTH; i++) send_rx(8'h30 + 8'(i), 1'b1);
    check("full_ovf", ovf_o, 1'b0);
    check("full_head", key_dat_o, 8'h30);
    rx_dat = 8'h7E; rx_push = 1'b1; rx_stb = 1'b1; key_rd = 1'b1;
    tick();
    rx_stb = 1'b0; rx_push = 1'b0; key_rd = 1'b0;
    check("full_pushpop_ovf", ovf_o, 1'b0);
    send_rx(8'h7F, 1'b1);
    check("ovf_set", ovf_o, 1'b1);
    for (int i = 0; i < DEPTH; i++) begin
      check("drain", key_dat_o, (i < DEPTH - 1) ? 8'h31 + 8'(i) : 8'h7E);
      pop();
    end
    check("drain_empty", key_vld_o, 1'b0);
    check("ovf_sticky", ovf_o, 1'b1);

    // reset in the middle of a command, then BAT failure
    send_rx(8'h55, 1'b1);
    pulse_led(3'b001);
    expect_tx(8'hED, 1'b0, 8'h00);
    rst = 1'b1;
    tick();
    check("mid_rst_busy", busy_o, 1'b1);
    check("mid_rst_req", tx_req_o, 1'b0);
    check("mid_rst_dat", tx_dat_o, 8'h00);
    check("mid_rst_init", init_done_o, 1'b0);
    check("mid_rst_err", err_o, 1'b0);
    check("mid_rst_ovf", ovf_o, 1'b0);
    check("mid_rst_vld", key_vld_o, 1'b0);
    rst = 1'b0;
    expect_tx(8'hFF, 1'b0, 8'h00);
    send_rx(8'hFA, 1'b0);
    send_rx(8'hFC, 1'b0);
    check("bat_fail_err", err_o, 1'b1);
    check("bat_fail_init", init_done_o, 1'b0);
    tick();
    check("bat_fail_idle", busy_o, 1'b0);

    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    n_fail++;
    $display("FAIL watchdog: simulation did not complete by %0t", $time);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $fatal(1, "watchdog");
  end

endmodule
